// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access path: Zicsr operation encoding,
// access sequencer states, privilege levels and CSR address field positions.
package csr_pkg;

    // Zicsr funct3[1:0]; 00 is not a CSR operation.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } csr_acc_state_t;

    typedef enum logic [1:0] {
        PRIV_U    = 2'd0,
        PRIV_S    = 2'd1,
        PRIV_RSVD = 2'd2,
        PRIV_M    = 2'd3
    } priv_mode_t;

    // CSR address fields: [11:10] == 11 marks a read-only CSR, [9:8] is the
    // lowest privilege level allowed to access it.
    localparam int          CSR_RO_HI   = 11;
    localparam int          CSR_RO_LO   = 10;
    localparam int          CSR_PRIV_HI = 9;
    localparam int          CSR_PRIV_LO = 8;
    localparam logic [1:0]  CSR_RO_VAL  = 2'b11;

endpackage

// File: rtl/csr_wdata_alu.sv
// Write-data generator for CSR read-modify-write: RW replaces, RS sets bits,
// RC clears bits. Purely combinational so the CSR file can reuse it.
module csr_wdata_alu
    import csr_pkg::*;
(
    input  csr_op_t     op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] src_i,
    output logic [31:0] wdata_o
);

    // Select the new CSR value from the old value and the source operand.
    always_comb begin
        wdata_o = '0;
        case (op_i)
            CSR_OP_RW: wdata_o = src_i;
            CSR_OP_RS: wdata_o = old_i | src_i;
            CSR_OP_RC: wdata_o = old_i & ~src_i;
            default:   wdata_o = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR bus initiator: takes one decoded Zicsr instruction from execute, runs the
// read / modify / write sequence against the CSR file and hands the old value,
// rd and an illegal flag to writeback. One access in flight at a time.
//
// Optional feature macro: CSR_PRIV_CHECK_EN -- when defined, privilege and
// read-only violations are caught at accept time without any bus access.
//
// state      | meaning
// IDLE       | ready for a new instruction (req_ready=1)
// RD_REQ     | read request on the CSR bus, waiting for csr_req_ready
// RD_WAIT    | waiting for the read response (timeout counter running)
// WR_REQ     | write request on the CSR bus, waiting for csr_req_ready
// WR_WAIT    | waiting for the write response (timeout counter running)
// RESP       | result presented to writeback until res_ready
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int RSP_TIMEOUT = 15
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr_addr,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_value,
    input  logic [4:0]  req_rd,
    input  logic [1:0]  priv_mode,
    output logic        csr_req_valid,
    input  logic        csr_req_ready,
    output logic        csr_req_write,
    output logic [11:0] csr_req_addr,
    output logic [31:0] csr_req_wdata,
    input  logic        csr_rsp_valid,
    input  logic [31:0] csr_rsp_rdata,
    input  logic        csr_rsp_error,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_rd,
    output logic        res_wen,
    output logic [31:0] res_value,
    output logic        res_illegal
);

    localparam int CNT_W = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

    csr_acc_state_t   state_q;
    csr_op_t          op_q;
    logic [31:0]      src_q;
    logic [31:0]      old_q;
    logic [4:0]       rd_q;
    logic             do_read_q;
    logic             do_write_q;
    logic [CNT_W-1:0] cnt_q;

    logic             req_ready_q;
    logic             csr_req_valid_q;
    logic             csr_req_write_q;
    logic [11:0]      csr_req_addr_q;
    logic [31:0]      csr_req_wdata_q;
    logic             res_valid_q;
    logic [4:0]       res_rd_q;
    logic             res_wen_q;
    logic [31:0]      res_value_q;
    logic             res_illegal_q;

    csr_op_t          req_op;
    logic [31:0]      req_src;
    logic             req_do_read;
    logic             req_do_write;
    logic             req_priv_fail;
    logic             req_illegal;
    logic             rsp_timeout;
    logic             rsp_ok;
    logic             rsp_fail;

    csr_op_t          alu_op;
    logic [31:0]      alu_old;
    logic [31:0]      alu_src;
    logic [31:0]      alu_wdata;

    assign req_op       = csr_op_t'(req_funct3[1:0]);
    assign req_src      = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_value;
    assign req_do_read  = !(req_op == CSR_OP_RW && req_rd == 5'd0);
    assign req_do_write = (req_op == CSR_OP_RW) || (req_rs1_idx != 5'd0);

`ifdef CSR_PRIV_CHECK_EN
    assign req_priv_fail =
        (req_csr_addr[CSR_PRIV_HI:CSR_PRIV_LO] > priv_mode) ||
        (req_do_write && req_csr_addr[CSR_RO_HI:CSR_RO_LO] == CSR_RO_VAL);
`else
    // Without local checks, protection comes only from csr_rsp_error.
    logic unused_priv;
    assign unused_priv   = ^priv_mode;
    assign req_priv_fail = 1'b0;
`endif

    assign req_illegal = (req_op == CSR_OP_NONE) || req_priv_fail;

    // A timeout is only honoured when no response arrives in the same cycle.
    assign rsp_timeout = (RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(RSP_TIMEOUT));
    assign rsp_ok      = csr_rsp_valid && !csr_rsp_error;
    assign rsp_fail    = (csr_rsp_valid && csr_rsp_error) || (!csr_rsp_valid && rsp_timeout);

    // Write data is computed on the cycle that launches the write: from IDLE
    // (write-only, no old value) or from RD_WAIT (old value = response data).
    assign alu_op  = (state_q == ST_IDLE) ? req_op  : op_q;
    assign alu_src = (state_q == ST_IDLE) ? req_src : src_q;
    assign alu_old = (state_q == ST_RD_WAIT) ? csr_rsp_rdata : 32'd0;

    csr_wdata_alu u_wdata_alu (
        .op_i    (alu_op),
        .old_i   (alu_old),
        .src_i   (alu_src),
        .wdata_o (alu_wdata)
    );

    // Access sequencer with registered bus and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            op_q            <= CSR_OP_NONE;
            src_q           <= '0;
            old_q           <= '0;
            rd_q            <= '0;
            do_read_q       <= 1'b0;
            do_write_q      <= 1'b0;
            cnt_q           <= '0;
            req_ready_q     <= 1'b1;
            csr_req_valid_q <= 1'b0;
            csr_req_write_q <= 1'b0;
            csr_req_addr_q  <= '0;
            csr_req_wdata_q <= '0;
            res_valid_q     <= 1'b0;
            res_rd_q        <= '0;
            res_wen_q       <= 1'b0;
            res_value_q     <= '0;
            res_illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q    <= 1'b0;
                        op_q           <= req_op;
                        src_q          <= req_src;
                        old_q          <= '0;
                        rd_q           <= req_rd;
                        do_read_q      <= req_do_read;
                        do_write_q     <= req_do_write;
                        csr_req_addr_q <= req_csr_addr;
                        if (req_illegal) begin
                            res_valid_q   <= 1'b1;
                            res_rd_q      <= req_rd;
                            res_wen_q     <= 1'b0;
                            res_value_q   <= '0;
                            res_illegal_q <= 1'b1;
                            state_q       <= ST_RESP;
                        end else if (req_do_read) begin
                            csr_req_valid_q <= 1'b1;
                            csr_req_write_q <= 1'b0;
                            csr_req_wdata_q <= '0;
                            state_q         <= ST_RD_REQ;
                        end else begin
                            csr_req_valid_q <= 1'b1;
                            csr_req_write_q <= 1'b1;
                            csr_req_wdata_q <= alu_wdata;
                            state_q         <= ST_WR_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (csr_req_ready) begin
                        csr_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rsp_ok) begin
                        old_q <= csr_rsp_rdata;
                        if (do_write_q) begin
                            csr_req_valid_q <= 1'b1;
                            csr_req_write_q <= 1'b1;
                            csr_req_wdata_q <= alu_wdata;
                            state_q         <= ST_WR_REQ;
                        end else begin
                            res_valid_q   <= 1'b1;
                            res_rd_q      <= rd_q;
                            res_wen_q     <= (rd_q != 5'd0);
                            res_value_q   <= csr_rsp_rdata;
                            res_illegal_q <= 1'b0;
                            state_q       <= ST_RESP;
                        end
                    end else if (rsp_fail) begin
                        res_valid_q   <= 1'b1;
                        res_rd_q      <= rd_q;
                        res_wen_q     <= 1'b0;
                        res_value_q   <= '0;
                        res_illegal_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (RSP_TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WR_REQ: begin
                    if (csr_req_ready) begin
                        csr_req_valid_q <= 1'b0;
                        csr_req_write_q <= 1'b0;
                        csr_req_wdata_q <= '0;
                        cnt_q           <= '0;
                        state_q         <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (rsp_ok) begin
                        res_valid_q   <= 1'b1;
                        res_rd_q      <= rd_q;
                        res_wen_q     <= do_read_q && (rd_q != 5'd0);
                        res_value_q   <= old_q;
                        res_illegal_q <= 1'b0;
                        state_q       <= ST_RESP;
                    end else if (rsp_fail) begin
                        res_valid_q   <= 1'b1;
                        res_rd_q      <= rd_q;
                        res_wen_q     <= 1'b0;
                        res_value_q   <= '0;
                        res_illegal_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (RSP_TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_rd_q      <= '0;
                        res_wen_q     <= 1'b0;
                        res_value_q   <= '0;
                        res_illegal_q <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready_q     <= 1'b1;
                    csr_req_valid_q <= 1'b0;
                    res_valid_q     <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign csr_req_valid = csr_req_valid_q;
    assign csr_req_write = csr_req_write_q;
    assign csr_req_addr  = csr_req_addr_q;
    assign csr_req_wdata = csr_req_wdata_q;
    assign res_valid     = res_valid_q;
    assign res_rd        = res_rd_q;
    assign res_wen       = res_wen_q;
    assign res_value     = res_value_q;
    assign res_illegal   = res_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: a CSR-file slave with programmable ready
// delay, response delay and error injection, plus a reference model that
// derives the expected bus operations, result and latency from the Zicsr rules.
module tb_csr_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_value;
    logic [4:0]  req_rd;
    logic [1:0]  priv_mode;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic        csr_req_write;
    logic [11:0] csr_req_addr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_error;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_rd;
    logic        res_wen;
    logic [31:0] res_value;
    logic        res_illegal;

    localparam int TIMEOUT = 15;

    csr_access_unit #(.RSP_TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_csr_addr  (req_csr_addr),
        .req_rs1_idx   (req_rs1_idx),
        .req_rs1_value (req_rs1_value),
        .req_rd        (req_rd),
        .priv_mode     (priv_mode),
        .csr_req_valid (csr_req_valid),
        .csr_req_ready (csr_req_ready),
        .csr_req_write (csr_req_write),
        .csr_req_addr  (csr_req_addr),
        .csr_req_wdata (csr_req_wdata),
        .csr_rsp_valid (csr_rsp_valid),
        .csr_rsp_rdata (csr_rsp_rdata),
        .csr_rsp_error (csr_rsp_error),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_rd        (res_rd),
        .res_wen       (res_wen),
        .res_value     (res_value),
        .res_illegal   (res_illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
    } bus_rec_t;

    bus_rec_t    bus_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    int          sl_ready_delay = 0;
    int          sl_rsp_extra   = 0;
    logic        sl_err_rd = 1'b0;
    logic        sl_err_wr = 1'b0;
    logic        sl_no_rsp = 1'b0;
    logic [31:0] sl_rdata  = 32'd0;
    int          stab_err  = 0;

    int          wcnt = 0;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic        pwr  = 1'b0;
    logic        have_prev = 1'b0;
    logic [11:0] p_addr;
    logic        p_wr;
    logic [31:0] p_wdata;

    int          r_lat;
    logic [31:0] r_value;
    logic        r_wen;
    logic        r_ill;
    logic [4:0]  r_rd;
    int          hold_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // CSR file slave: everything is driven mid-cycle on the falling edge.
    initial begin
        csr_req_ready = 1'b0;
        csr_rsp_valid = 1'b0;
        csr_rsp_rdata = 32'd0;
        csr_rsp_error = 1'b0;
        forever begin
            @(negedge clock);
            csr_rsp_valid = 1'b0;
            csr_rsp_error = 1'b0;
            csr_rsp_rdata = $urandom;
            csr_req_ready = 1'b0;
            if (reset) begin
                pend = 1'b0;
                wcnt = 0;
                have_prev = 1'b0;
            end else begin
                if (pend) begin
                    if (pcnt == 0) begin
                        csr_rsp_valid = 1'b1;
                        csr_rsp_rdata = pwr ? $urandom : sl_rdata;
                        csr_rsp_error = pwr ? sl_err_wr : sl_err_rd;
                        pend = 1'b0;
                    end else begin
                        pcnt--;
                    end
                end
                if (csr_req_valid) begin
                    if (have_prev && (csr_req_addr !== p_addr || csr_req_write !== p_wr ||
                                      csr_req_wdata !== p_wdata))
                        stab_err++;
                    have_prev = 1'b1;
                    p_addr  = csr_req_addr;
                    p_wr    = csr_req_write;
                    p_wdata = csr_req_wdata;
                    if (wcnt >= sl_ready_delay) begin
                        csr_req_ready = 1'b1;
                        bus_log.push_back('{wr: csr_req_write, addr: csr_req_addr, wdata: csr_req_wdata});
                        if (!sl_no_rsp) begin
                            pend = 1'b1;
                            pcnt = sl_rsp_extra;
                            pwr  = csr_req_write;
                        end
                        have_prev = 1'b0;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                    have_prev = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                         input logic [31:0] v, input logic [4:0] rd, input logic [1:0] pm);
        @(negedge clock);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid     = 1'b1;
        req_funct3    = f3;
        req_csr_addr  = a;
        req_rs1_idx   = idx;
        req_rs1_value = v;
        req_rd        = rd;
        priv_mode     = pm;
        @(posedge clock);
        #1;
        req_valid     = 1'b0;
        req_funct3    = 3'($urandom);
        req_csr_addr  = 12'($urandom);
        req_rs1_idx   = 5'($urandom);
        req_rs1_value = $urandom;
        req_rd        = 5'($urandom);
    endtask

    // Waits for res_valid (cycles counted from the accept edge), optionally
    // holds res_ready low, then completes the handshake.
    task automatic get_result(input int hold, output bit got);
        got = 1'b0;
        r_lat = 0;
        hold_err = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            r_lat++;
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("res_valid_arrival", 32'd0, 32'd1);
        end else begin
            r_value = res_value;
            r_wen   = res_wen;
            r_ill   = res_illegal;
            r_rd    = res_rd;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                if (res_valid !== 1'b1 || res_value !== r_value || res_wen !== r_wen ||
                    res_illegal !== r_ill || res_rd !== r_rd)
                    hold_err++;
            end
            res_ready = 1'b1;
            @(posedge clock);
            #1;
            res_ready = 1'b0;
            @(negedge clock);
            chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
            chk("res_valid_dropped", {31'd0, res_valid}, 32'd0);
        end
    endtask

    task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] v, input logic [4:0] rd, input logic [1:0] pm,
                       input logic [31:0] oldv, input logic rerr, input logic werr,
                       input int d, input int e, input int hold, input logic no_rsp);
        logic [1:0]  op;
        logic [31:0] src;
        logic [31:0] old;
        logic [31:0] wd;
        logic        rd_do;
        logic        wr_do;
        logic        ill;
        logic        exp_wen;
        logic [31:0] exp_val;
        int          exp_lat;
        bus_rec_t    exp_ops[$];
        bit          got;

        sl_ready_delay = d;
        sl_rsp_extra   = e;
        sl_err_rd      = rerr;
        sl_err_wr      = werr;
        sl_no_rsp      = no_rsp;
        sl_rdata       = oldv;
        bus_log.delete();
        stab_err = 0;

        issue(f3, a, idx, v, rd, pm);
        get_result(hold, got);

        op    = f3[1:0];
        src   = f3[2] ? {27'd0, idx} : v;
        rd_do = !(op == 2'b01 && rd == 5'd0);
        wr_do = (op == 2'b01) || (idx != 5'd0);
        ill   = (op == 2'b00);
`ifdef CSR_PRIV_CHECK_EN
        if (a[9:8] > pm || (wr_do && a[11:10] == 2'b11)) ill = 1'b1;
`endif
        old = 32'd0;
        if (!ill) begin
            if (rd_do) begin
                exp_ops.push_back('{wr: 1'b0, addr: a, wdata: 32'd0});
                old = oldv;
                if (rerr || no_rsp) ill = 1'b1;
            end
            if (!ill && wr_do) begin
                if (op == 2'b01)      wd = src;
                else if (op == 2'b10) wd = old | src;
                else                  wd = old & ~src;
                exp_ops.push_back('{wr: 1'b1, addr: a, wdata: wd});
                if (werr || no_rsp) ill = 1'b1;
            end
        end
        exp_val = ill ? 32'd0 : old;
        exp_wen = !ill && rd_do && (rd != 5'd0);
        exp_lat = 1 + exp_ops.size() * (2 + d + e);

        if (got) begin
            if (!no_rsp) chk("latency", r_lat, exp_lat);
            chk("res_illegal", {31'd0, r_ill}, {31'd0, ill});
            chk("res_wen", {31'd0, r_wen}, {31'd0, exp_wen});
            chk("res_value", r_value, exp_val);
            chk("res_rd", {27'd0, r_rd}, {27'd0, rd});
            chk("res_hold_stable", hold_err, 0);
        end
        chk("bus_op_count", bus_log.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < bus_log.size(); i++) begin
            chk("bus_write_flag", {31'd0, bus_log[i].wr}, {31'd0, exp_ops[i].wr});
            chk("bus_addr", {20'd0, bus_log[i].addr}, {20'd0, exp_ops[i].addr});
            chk("bus_wdata", bus_log[i].wdata, exp_ops[i].wdata);
        end
        chk("req_hold_stable", stab_err, 0);
        sl_no_rsp = 1'b0;
        sl_err_rd = 1'b0;
        sl_err_wr = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_funct3    = 3'd0;
        req_csr_addr  = 12'd0;
        req_rs1_idx   = 5'd0;
        req_rs1_value = 32'd0;
        req_rd        = 5'd0;
        priv_mode     = 2'd3;
        res_ready     = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_csr_req_valid", {31'd0, csr_req_valid}, 32'd0);
        chk("rst_csr_req_write", {31'd0, csr_req_write}, 32'd0);
        chk("rst_csr_req_addr", {20'd0, csr_req_addr}, 32'd0);
        chk("rst_csr_req_wdata", csr_req_wdata, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_out", {26'd0, res_wen, res_illegal, res_rd}, 32'd0);
        chk("rst_res_value", res_value, 32'd0);

        // CSRRS rd=5, rs1=x0, read-only access to 0xC00.
        run(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd5, 2'd3, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
        chk("t_rs_lat3", r_lat, 3);
        chk("t_rs_value", r_value, 32'h0000_1234);
        chk("t_rs_wen", {31'd0, r_wen}, 32'd1);
        chk("t_rs_one_read", bus_log.size(), 1);

        // CSRRW rd=0: write only.
        run(3'b001, 12'h340, 5'd9, 32'hDEAD_BEEF, 5'd0, 2'd3, 32'h1111_2222, 0, 0, 0, 0, 0, 0);
        chk("t_rw_lat3", r_lat, 3);
        chk("t_rw_wen", {31'd0, r_wen}, 32'd0);
        if (bus_log.size() == 1) chk("t_rw_wdata", bus_log[0].wdata, 32'hDEAD_BEEF);
        else chk("t_rw_one_write", bus_log.size(), 1);

        // CSRRCI rd=3, zimm=0x0F, old 0xFF.
        run(3'b111, 12'h300, 5'h0F, 32'h0, 5'd3, 2'd3, 32'h0000_00FF, 0, 0, 0, 0, 0, 0);
        chk("t_rci_lat5", r_lat, 5);
        chk("t_rci_value", r_value, 32'h0000_00FF);
        if (bus_log.size() == 2) chk("t_rci_wdata", bus_log[1].wdata, 32'h0000_00F0);
        else chk("t_rci_two_ops", bus_log.size(), 2);

        // Read error: no write, illegal.
        run(3'b010, 12'h7C0, 5'd4, 32'h5, 5'd6, 2'd3, 32'hABCD_0000, 1, 0, 0, 0, 0, 0);
        chk("t_rderr_ill", {31'd0, r_ill}, 32'd1);
        chk("t_rderr_no_write", bus_log.size(), 1);

        // Illegal funct3=100: result at cycle 1, no bus.
        run(3'b100, 12'h300, 5'd1, 32'h1, 5'd1, 2'd3, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("t_f3_lat1", r_lat, 1);
        chk("t_f3_ill", {31'd0, r_ill}, 32'd1);
        chk("t_f3_no_bus", bus_log.size(), 0);

        // Slave ready low 4 cycles, writeback stalls 3 cycles.
        run(3'b001, 12'h305, 5'd7, 32'h8000_0001, 5'd2, 2'd3, 32'h0BAD_F00D, 0, 0, 4, 0, 3, 0);
        chk("t_stall_lat", r_lat, 1 + 2 * (2 + 4));

        // Write error after a successful read.
        run(3'b011, 12'h344, 5'd2, 32'hF0F0_F0F0, 5'd8, 2'd3, 32'hFFFF_FFFF, 0, 1, 1, 1, 1, 0);
        chk("t_wrerr_value", r_value, 32'd0);

        // No response ever: timeout after RSP_TIMEOUT wait cycles.
        run(3'b010, 12'hB00, 5'd0, 32'h0, 5'd9, 2'd3, 32'h1234_5678, 0, 0, 0, 0, 0, 1);
        chk("t_tmo_ill", {31'd0, r_ill}, 32'd1);
        chk("t_tmo_wait_len", {31'd0, (r_lat >= TIMEOUT + 2) && (r_lat <= TIMEOUT + 4)}, 32'd1);

`ifdef CSR_PRIV_CHECK_EN
        // U-mode write to a machine CSR is rejected locally.
        run(3'b001, 12'h300, 5'd1, 32'h1, 5'd1, 2'd0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("t_priv_lat1", r_lat, 1);
        chk("t_priv_no_bus", bus_log.size(), 0);
`endif

        // Reset while waiting for the write response.
        sl_ready_delay = 0;
        sl_rsp_extra   = 6;
        sl_no_rsp      = 1'b0;
        bus_log.delete();
        issue(3'b001, 12'h305, 5'd4, 32'h1357_2468, 5'd0, 2'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus_log.size() > 0) break;
        end
        chk("t_rst_write_issued", bus_log.size(), 1);
        @(negedge clock);
        chk("t_rst_in_wait_valid", {31'd0, csr_req_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("t_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t_rst_csr_req_valid", {31'd0, csr_req_valid}, 32'd0);
        chk("t_rst_res_valid", {31'd0, res_valid}, 32'd0);
        reset = 1'b0;
        sl_rsp_extra = 0;
        repeat (4) @(negedge clock);
        chk("t_rst_quiet_res", {31'd0, res_valid}, 32'd0);
        chk("t_rst_quiet_req", {31'd0, csr_req_valid}, 32'd0);

        // Randomised instructions against the model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [4:0]  idx;
            logic [4:0]  rd;
            f3  = 3'($urandom_range(0, 7));
            idx = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run(f3, 12'($urandom), idx, $urandom, rd, 2'd3, $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the CSR bus. Accepts one decoded Zicsr instruction (CSRRW/RS/RC and immediate forms) from execute, runs the read / modify / write sequence against the CSR file over a valid/ready request + response bus, and returns the old CSR value, rd, and an illegal-instruction flag to writeback. Sits between execute and the CSR file and serialises CSR accesses, one in flight.

## Interface
- RSP_TIMEOUT, 15: max cycles waiting for csr_rsp_valid before the access is declared illegal; 0 disables the timeout.
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid / req_ready  in / out  1  instruction handshake from execute
- req_funct3  in  3  Zicsr funct3: bit2 = immediate source; [1:0] 01 RW, 10 RS, 11 RC
- req_csr_addr  in  12  CSR address, instr[31:20]
- req_rs1_idx  in  5  rs1 index; doubles as zimm
- req_rs1_value  in  32  rs1 register value
- req_rd  in  5  destination index
- priv_mode  in  2  current privilege (U=0, S=1, M=3)
- csr_req_valid / csr_req_ready  out / in  1  CSR bus request handshake
- csr_req_write  out  1  0 read, 1 write
- csr_req_addr  out  12  CSR address
- csr_req_wdata  out  32  write data; 0 on reads
- csr_rsp_valid  in  1  response strobe, one cycle, no backpressure
- csr_rsp_rdata  in  32  read data, valid with csr_rsp_valid on reads
- csr_rsp_error  in  1  CSR absent or not accessible
- res_valid / res_ready  out / in  1  result handshake to writeback
- res_rd  out  5  destination index
- res_wen  out  1  write res_value to res_rd
- res_value  out  32  old CSR value
- res_illegal  out  1  raise illegal-instruction exception

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE: req_ready=1 only here. On accept, latch all req_* fields.
- Source: src = funct3[2] ? zero-extended rs1_idx : rs1_value.
- do_read = !(op==RW && rd==0). do_write = (op==RW) || (rs1_idx!=0).
- funct3[1:0]==00: illegal. Go to RESP with res_illegal=1, no bus access.
- Otherwise go to RD_REQ if do_read, else WR_REQ.
- RD_REQ: assert csr_req_valid with write=0; hold address stable until csr_req_ready. Then go to RD_WAIT.
- RD_WAIT: on csr_rsp_valid, latch rdata into res_value.
  - If error: illegal, go to RESP.
  - Else go to WR_REQ if do_write, else RESP.
- WR_REQ: csr_req_write=1, wdata = RW: src; RS: old|src; RC: old&~src (old = 0 when no read). Hold until csr_req_ready, then go to WR_WAIT.
- WR_WAIT: on csr_rsp_valid go to RESP; error there sets illegal.
- RESP: res_valid=1, held stable until res_ready, then go to IDLE.
  - res_wen = !illegal && do_read && rd!=0.
  - On illegal, res_wen=0 and res_value=0.
- Timeout: counter runs in RD_WAIT/WR_WAIT. When count == RSP_TIMEOUT without a response, behave as an error. Responses arriving outside a WAIT state are ignored.
- A failed read never issues a write.

## Timing
- All outputs are registered.
- Reset values: state IDLE, req_ready 1, all other outputs 0, counters 0.
- Reset mid-operation: return to IDLE next cycle and drop any in-flight request. The CSR file shares reset.
- Latency with a zero-wait slave (ready=1, response the cycle after the request handshake), accept at cycle 0:
  - read+write: res_valid at cycle 5
  - read only or write only: res_valid at cycle 3
  - illegal funct3: res_valid at cycle 1
- Back-to-back: the next accept is possible the cycle after the RESP handshake.

## Configuration
- CSR_PRIV_CHECK_EN defined: at accept, the access is illegal with no bus access if either:
  - req_csr_addr[9:8] > priv_mode, or
  - do_write and req_csr_addr[11:10]==2'b11.
  - Result reaches RESP at cycle 1.
- Undefined: no local checks; protection relies solely on csr_rsp_error.

## Structure
- csr_pkg holds:
  - csr_op_t enum (RW=01, RS=10, RC=11)
  - csr_acc_state_t
  - priv_mode_t
  - CSR address field constants (RO field [11:10], privilege field [9:8])
- Sub-module csr_wdata_alu: combinational (op, old, src) -> wdata, reused by the CSR file for atomic updates.

## Test plan
- CSRRS rd=5, rs1=x0, addr 0xC00, slave returns 0x0000_1234 -> exactly one read, no write; res_rd=5, res_wen=1, res_value=0x1234, res_valid at cycle 3.
- CSRRW rd=0, rs1_value=0xDEAD_BEEF, addr 0x340 -> no read, one write with wdata 0xDEADBEEF; res_wen=0.
- CSRRCI rd=3, zimm=0x0F, old 0xFF -> read, then write wdata 0xF0; res_value 0xFF.
- Read returns csr_rsp_error=1 -> no write; res_illegal=1, res_wen=0. funct3=100 -> res_illegal at cycle 1, no csr_req_valid.
- csr_req_ready held low 4 cycles, res_ready held low 3 cycles -> request and result fields stable throughout; no response ever arrives with RSP_TIMEOUT=15 -> res_illegal after 15 wait cycles.
- Reset asserted in WR_WAIT -> next cycle IDLE, req_ready=1, csr_req_valid=0. With CSR_PRIV_CHECK_EN: priv U, CSRRW on 0x300 -> illegal, no bus activity.
